// File: rtl/cplx_float_narrow_pkg.sv
// Shared float32 field constants, rounding-mode encodings and the narrow-format width helper.
package cplx_float_narrow_pkg;

    localparam int F32_BIAS   = 127;
    localparam int F32_SIGN_W = 1;
    localparam int F32_EXP_W  = 8;
    localparam int F32_MAN_W  = 23;

    typedef enum int {
        RND_TRUNC = 0,
        RND_RNE   = 1
    } rnd_mode_t;

    typedef enum logic [1:0] {
        CLS_ZERO,
        CLS_NORM,
        CLS_INF,
        CLS_NAN
    } f32_class_t;

    function automatic int out_w(input int exp_w, input int man_w);
        return F32_SIGN_W + exp_w + man_w;
    endfunction

endpackage

// File: rtl/cplx_float_narrow_if.sv
// Streaming handshake bus: float32 complex samples in, packed narrow complex result out.
interface cplx_float_narrow_if #(
    parameter int OUT_W = 18
);
    logic                 in_valid;
    logic                 in_ready;
    logic [31:0]          re;
    logic [31:0]          im;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*OUT_W-1:0]   result;

    modport master (
        output in_valid, re, im, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  in_valid, re, im, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/cplx_float_narrow_lane.sv
// One float32 -> narrow float converter: unpack, round, pack/classify.
// All stages move together under the shared advance enable.
module float_narrow_lane
    import cplx_float_narrow_pkg::*;
#(
    parameter int EXP_W    = 6,
    parameter int MAN_W    = 11,
    parameter int RND_MODE = 1,
    parameter int SAT_INF  = 0,
    localparam int OUT_W   = out_w(EXP_W, MAN_W)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic [31:0]      value,
    output logic [OUT_W-1:0] word,
    output logic             ovf,
    output logic             unf
);

    localparam int DROP = F32_MAN_W - MAN_W;
    localparam int NE_W = 12;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;
    localparam logic signed [NE_W-1:0] NE_OFS = NE_W'(F32_BIAS - BIAS);
    localparam logic signed [NE_W-1:0] NE_MAX = NE_W'((1 << EXP_W) - 1);
    localparam bit USE_RNE = (RND_MODE == int'(RND_RNE));
    localparam bit USE_INF = (SAT_INF != 0);

    logic                   s0;
    logic [F32_EXP_W-1:0]   e0;
    logic [F32_MAN_W-1:0]   m0;
    f32_class_t             cls0;

    f32_class_t             cls1;
    logic                   s1, g1, st1, nz1;
    logic signed [NE_W-1:0] ne1;
    logic [MAN_W-1:0]       mk1;

    f32_class_t             cls1_fix;
    logic                   nz1_fix;
    logic                   inc;
    logic [MAN_W:0]         sum;

    f32_class_t             cls2;
    logic                   s2, nz2;
    logic signed [NE_W-1:0] ne2;
    logic [MAN_W-1:0]       man2;

    logic [OUT_W-1:0]       word_d;
    logic                   ovf_d, unf_d;

    assign {s0, e0, m0} = value;

    always_comb begin
        cls0 = CLS_NORM;
        if (e0 == '1)
            cls0 = (m0 != '0) ? CLS_NAN : CLS_INF;
        else if (e0 == '0)
            cls0 = CLS_ZERO;
    end

    // Underflow is judged on the unrounded exponent and becomes a flushed zero here.
    always_comb begin
        inc      = USE_RNE && g1 && (st1 || mk1[0]);
        sum      = {1'b0, mk1} + {{MAN_W{1'b0}}, inc};
        cls1_fix = cls1;
        nz1_fix  = nz1;
        if (cls1 == CLS_NORM && (ne1[NE_W-1] || ne1 == '0)) begin
            cls1_fix = CLS_ZERO;
            nz1_fix  = 1'b1;
        end
    end

    always_comb begin
        word_d = '0;
        ovf_d  = 1'b0;
        unf_d  = 1'b0;
        unique case (cls2)
            CLS_ZERO: begin
                word_d = {s2, {(OUT_W-1){1'b0}}};
                unf_d  = nz2;
            end
            CLS_INF: word_d = {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            CLS_NAN: word_d = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
            default: begin
                if (ne2 >= NE_MAX) begin
                    ovf_d  = 1'b1;
                    word_d = USE_INF ? {s2, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                     : {s2, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
                end else begin
                    word_d = {s2, ne2[EXP_W-1:0], man2};
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls1 <= CLS_ZERO;
            s1   <= 1'b0;
            g1   <= 1'b0;
            st1  <= 1'b0;
            nz1  <= 1'b0;
            ne1  <= '0;
            mk1  <= '0;
            cls2 <= CLS_ZERO;
            s2   <= 1'b0;
            nz2  <= 1'b0;
            ne2  <= '0;
            man2 <= '0;
            word <= '0;
            ovf  <= 1'b0;
            unf  <= 1'b0;
        end else if (advance) begin
            cls1 <= cls0;
            s1   <= s0;
            ne1  <= $signed(NE_W'(e0)) - NE_OFS;
            mk1  <= m0[F32_MAN_W-1 -: MAN_W];
            g1   <= m0[DROP-1];
            st1  <= |m0[DROP-2:0];
            nz1  <= (m0 != '0);

            cls2 <= cls1_fix;
            s2   <= s1;
            nz2  <= nz1_fix;
            ne2  <= ne1 + $signed(NE_W'(sum[MAN_W]));
            man2 <= sum[MAN_W] ? '0 : sum[MAN_W-1:0];

            word <= word_d;
            ovf  <= ovf_d;
            unf  <= unf_d;
        end
    end

endmodule

// File: rtl/cplx_float_narrow.sv
// Complex float32 -> narrow float converter: two identical lanes behind one stalling 3-stage pipeline.
module cplx_float_narrow
    import cplx_float_narrow_pkg::*;
#(
    parameter int EXP_W    = 6,
    parameter int MAN_W    = 11,
    parameter int RND_MODE = 1,
    parameter int SAT_INF  = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    cplx_float_narrow_if.slave  bus,
    input  logic                clr_flags,
    output logic [1:0]          ovf_flag,
    output logic [1:0]          unf_flag
);

    localparam int OUT_W = out_w(EXP_W, MAN_W);

    logic             advance;
    logic [2:0]       vld;
    logic [OUT_W-1:0] re_word, im_word;
    logic             re_ovf, re_unf, im_ovf, im_unf;

    assign advance       = bus.out_ready || !vld[2];
    assign bus.in_ready  = advance;
    assign bus.out_valid = vld[2];
    assign bus.result    = {re_word, im_word};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            vld <= '0;
        else if (advance)
            vld <= {vld[1:0], bus.in_valid};
    end

    // Flags accumulate only as a sample is handed downstream; clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_flag <= '0;
            unf_flag <= '0;
        end else if (clr_flags) begin
            ovf_flag <= '0;
            unf_flag <= '0;
        end else if (vld[2] && advance) begin
            ovf_flag <= ovf_flag | {re_ovf, im_ovf};
            unf_flag <= unf_flag | {re_unf, im_unf};
        end
    end

    float_narrow_lane #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .RND_MODE(RND_MODE), .SAT_INF(SAT_INF)
    ) u_re (
        .clk(clk), .rst_n(rst_n), .advance(advance), .value(bus.re),
        .word(re_word), .ovf(re_ovf), .unf(re_unf)
    );

    float_narrow_lane #(
        .EXP_W(EXP_W), .MAN_W(MAN_W), .RND_MODE(RND_MODE), .SAT_INF(SAT_INF)
    ) u_im (
        .clk(clk), .rst_n(rst_n), .advance(advance), .value(bus.im),
        .word(im_word), .ovf(im_ovf), .unf(im_unf)
    );

endmodule

// File: tb/tb_cplx_float_narrow.sv
// Bench for cplx_float_narrow: two parameterisations share one stimulus stream, checked against a value-level model.
module tb_cplx_float_narrow;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] re, im;
    logic        out_ready;
    logic        clr_flags;
    logic [1:0]  ovf_a, unf_a, ovf_b, unf_b;

    int checks = 0;
    int errors = 0;
    int accepted = 0;

    cplx_float_narrow_if #(.OUT_W(18)) bus_a ();
    cplx_float_narrow_if #(.OUT_W(18)) bus_b ();

    assign bus_a.in_valid  = in_valid;
    assign bus_a.re        = re;
    assign bus_a.im        = im;
    assign bus_a.out_ready = out_ready;
    assign bus_b.in_valid  = in_valid;
    assign bus_b.re        = re;
    assign bus_b.im        = im;
    assign bus_b.out_ready = out_ready;

    cplx_float_narrow #(.EXP_W(6), .MAN_W(11), .RND_MODE(1), .SAT_INF(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .clr_flags(clr_flags),
        .ovf_flag(ovf_a), .unf_flag(unf_a)
    );

    cplx_float_narrow #(.EXP_W(6), .MAN_W(11), .RND_MODE(0), .SAT_INF(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .bus(bus_b), .clr_flags(clr_flags),
        .ovf_flag(ovf_b), .unf_flag(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Value-level reference: quotient/remainder rounding against the half-ulp point.
    function automatic logic [17:0] narrow(input logic [31:0] f, input bit rne, input bit sat,
                                           output bit ovf, output bit unf);
        bit s;
        int e, m, ne, q, rem;
        s = f[31];
        e = int'(f[30:23]);
        m = int'(f[22:0]);
        ovf = 0;
        unf = 0;
        if (e == 255) return (m == 0) ? {s, 6'h3f, 11'h000} : {1'b0, 6'h3f, 11'h400};
        if (e == 0) begin
            unf = (m != 0);
            return {s, 17'h0};
        end
        ne = e - 127 + 31;
        if (ne <= 0) begin
            unf = 1;
            return {s, 17'h0};
        end
        q = m / 4096;
        rem = m % 4096;
        if (rne && (rem > 2048 || (rem == 2048 && (q % 2) == 1))) q++;
        if (q == 2048) begin
            q = 0;
            ne++;
        end
        if (ne >= 63) begin
            ovf = 1;
            return sat ? {s, 6'h3f, 11'h000} : {s, 6'h3e, 11'h7ff};
        end
        return {s, 6'(ne), 11'(q)};
    endfunction

    function automatic logic [31:0] rand_f32();
        logic        s;
        logic [7:0]  e;
        logic [22:0] m;
        s = 1'($urandom);
        m = 23'($urandom);
        case ($urandom_range(0, 7))
            0: begin e = 8'd0;   if ($urandom_range(0, 1) == 0) m = '0; end
            1: begin e = 8'hff;  if ($urandom_range(0, 1) == 0) m = '0; end
            2: e = 8'($urandom_range(94, 98));
            3: e = 8'($urandom_range(155, 160));
            4: begin e = 8'($urandom_range(90, 165)); m[11:0] = 12'h800; end
            5: begin e = 8'($urandom_range(150, 160)); m[22:11] = '1; end
            default: e = 8'($urandom_range(1, 254));
        endcase
        return {s, e, m};
    endfunction

    typedef struct packed {
        logic [35:0] res;
        logic [1:0]  ovf;
        logic [1:0]  unf;
    } exp_t;

    exp_t        q0[$], q1[$];
    exp_t        ex;
    bit          o1, u1, o2, u2;
    logic [35:0] res_s [2];
    logic        ov_s [2];
    logic [1:0]  ovf_s [2], unf_s [2];
    logic [1:0]  m_ovf [2], m_unf [2];
    logic        hold [2];
    logic [35:0] held [2];
    logic [1:0]  nxt_o, nxt_u;
    int          qsz;

    assign res_s[0] = bus_a.result;
    assign res_s[1] = bus_b.result;
    assign ov_s[0]  = bus_a.out_valid;
    assign ov_s[1]  = bus_b.out_valid;
    assign ovf_s[0] = ovf_a;
    assign ovf_s[1] = ovf_b;
    assign unf_s[0] = unf_a;
    assign unf_s[1] = unf_b;

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("reset_out_valid_%0d", d), ov_s[d], 0);
                check($sformatf("reset_result_%0d", d), res_s[d], 0);
                check($sformatf("reset_flags_%0d", d), {ovf_s[d], unf_s[d]}, 0);
                m_ovf[d] = '0;
                m_unf[d] = '0;
                hold[d]  = 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int d = 0; d < 2; d++) begin
                if (hold[d]) begin
                    check($sformatf("stall_valid_%0d", d), ov_s[d], 1);
                    check($sformatf("stall_result_%0d", d), res_s[d], held[d]);
                end
                check($sformatf("ovf_flag_%0d", d), ovf_s[d], m_ovf[d]);
                check($sformatf("unf_flag_%0d", d), unf_s[d], m_unf[d]);
                nxt_o = m_ovf[d];
                nxt_u = m_unf[d];
                if (ov_s[d] && out_ready) begin
                    qsz = (d == 0) ? q0.size() : q1.size();
                    if (qsz == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_output_%0d: got result %h with nothing pending, required no output", d, res_s[d]);
                    end else begin
                        ex = (d == 0) ? q0.pop_front() : q1.pop_front();
                        check($sformatf("result_%0d", d), res_s[d], ex.res);
                        nxt_o = nxt_o | ex.ovf;
                        nxt_u = nxt_u | ex.unf;
                    end
                end
                if (clr_flags) begin
                    nxt_o = '0;
                    nxt_u = '0;
                end
                m_ovf[d] = nxt_o;
                m_unf[d] = nxt_u;
                hold[d]  = ov_s[d] && !out_ready;
                held[d]  = res_s[d];
            end
            if (in_valid && bus_a.in_ready) begin
                ex.res = {narrow(re, 1, 0, o1, u1), narrow(im, 1, 0, o2, u2)};
                ex.ovf = {o1, o2};
                ex.unf = {u1, u2};
                q0.push_back(ex);
                ex.res = {narrow(re, 0, 1, o1, u1), narrow(im, 0, 1, o2, u2)};
                ex.ovf = {o1, o2};
                ex.unf = {u1, u2};
                q1.push_back(ex);
                accepted++;
            end
        end
    end

    task automatic send_one(input logic [31:0] a, input logic [31:0] b,
                            input logic [35:0] exp_a, input logic [35:0] exp_b,
                            input bit clr_on_out, input string tag);
        int lat;
        re = a;
        im = b;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!bus_a.out_valid && lat < 10) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, 3);
        check({tag, "_a"}, bus_a.result, exp_a);
        check({tag, "_b"}, bus_b.result, exp_b);
        clr_flags = clr_on_out;
        @(posedge clk); #1;
        clr_flags = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit po, pu;
        int cyc, seen;
        rst_n = 1'b0;
        in_valid = 1'b0;
        re = '0;
        im = '0;
        out_ready = 1'b0;
        clr_flags = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", bus_a.in_ready, 1);

        check("pin_rne", narrow(32'h3F801800, 1, 0, po, pu), 18'h0F802);
        check("pin_trunc", narrow(32'h3F801800, 0, 1, po, pu), 18'h0F801);
        check("pin_sat_finite", narrow(32'h7149F2CA, 1, 0, po, pu), 18'h1F7FF);
        check("pin_sat_finite_ovf", po, 1);
        check("pin_sat_inf", narrow(32'h7149F2CA, 1, 1, po, pu), 18'h1F800);
        check("pin_underflow", narrow(32'h30000000, 1, 0, po, pu), 18'h00000);
        check("pin_underflow_unf", pu, 1);
        check("pin_neg", narrow(32'hC77082D7, 1, 0, po, pu), 18'h37708);
        check("pin_nan", narrow(32'h7FC00000, 1, 0, po, pu), 18'h1FC00);
        check("pin_carry", narrow(32'h4EFFF800, 1, 0, po, pu), 18'h1F000);
        check("pin_carry_ovf", narrow(32'h4F7FF800, 1, 0, po, pu), 18'h1F7FF);

        send_one(32'hC77082D7, 32'hC77082D7, {18'h37708, 18'h37708}, {18'h37708, 18'h37708}, 0, "neg_normal");
        check("neg_normal_flags", {ovf_a, unf_a, ovf_b, unf_b}, 0);
        send_one(32'h3F801800, 32'h3F800800, {18'h0F802, 18'h0F800}, {18'h0F801, 18'h0F800}, 0, "round_tie");
        send_one(32'h7149F2CA, 32'h30000000, {18'h1F7FF, 18'h00000}, {18'h1F800, 18'h00000}, 1, "ovf_clr_same_cycle");
        check("clr_beats_set_a", {ovf_a, unf_a}, 0);
        send_one(32'h7149F2CA, 32'h30000000, {18'h1F7FF, 18'h00000}, {18'h1F800, 18'h00000}, 0, "ovf_unf");
        repeat (3) @(posedge clk);
        #1;
        check("sticky_ovf_a", ovf_a, 2'b10);
        check("sticky_unf_a", unf_a, 2'b01);
        check("sticky_ovf_b", ovf_b, 2'b10);
        check("sticky_unf_b", unf_b, 2'b01);
        clr_flags = 1'b1;
        @(posedge clk); #1;
        clr_flags = 1'b0;
        check("cleared_flags", {ovf_a, unf_a, ovf_b, unf_b}, 0);
        send_one(32'h7FC00000, 32'hFF800000, {18'h1FC00, 18'h3F800}, {18'h1FC00, 18'h3F800}, 0, "nan_inf");

        accepted = 0;
        cyc = 0;
        while (accepted < 8192 && cyc < 50000) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            re        = rand_f32();
            im        = rand_f32();
            out_ready = ($urandom_range(0, 3) != 0);
            clr_flags = ($urandom_range(0, 63) == 0);
            @(posedge clk); #1;
            cyc++;
        end
        in_valid  = 1'b0;
        clr_flags = 1'b0;
        out_ready = 1'b1;
        check("stream_accepted", accepted, 8192);
        cyc = 0;
        while ((q0.size() != 0 || q1.size() != 0) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("drain_pending_a", q0.size(), 0);
        check("drain_pending_b", q1.size(), 0);

        for (int i = 0; i < 3; i++) begin
            re = rand_f32();
            im = rand_f32();
            in_valid = 1'b1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset_flush_valid_a", bus_a.out_valid, 0);
        check("reset_flush_valid_b", bus_b.out_valid, 0);
        check("reset_flush_result_a", bus_a.result, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (bus_a.out_valid || bus_b.out_valid) seen++;
        end
        check("no_stale_after_reset", seen, 0);
        check("in_ready_after_flush", bus_a.in_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
